// File: rtl/l1_ctrl_pkg.sv
// Shared types for the L1 refill controller: FSM states,
// captured op kind, bus size codes and the line offset width.
package l1_ctrl_pkg;

  localparam int LINE_OFS_W = 11;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LINE,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_LINE,
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/l1_refill_ctrl_watchdog.sv
// bus_watchdog: counts bus_req cycles since the last ack and
// flags expiry on the TIMEOUT-th cycle. TIMEOUT=0 never expires.
// Ports: i_clk, i_rst (sync, high), i_clr, i_run, o_expire.
module bus_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_run && (TIMEOUT != 0)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt is 0 in the first waiting cycle, so expiry on
  // TIMEOUT-1 ends the TIMEOUT-th cycle of bus_req.
  assign o_expire = (TIMEOUT != 0) && i_run &&
                    (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl: runs L1 line refills, uncached reads and
// write-throughs as 64-bit beats on the system bus.
// Ports: clk, rst (sync, high); L1 side read_line_req, read_req,
// write_through_req, pa, L1_size, wt_data -> line_data, addr_count,
// line_write, cache_entry_write, trans_rdy, bus_error; bus side
// bus_req, bus_we, bus_addr, bus_size, bus_wdata <- bus_rdata,
// bus_ack, bus_err.
module l1_refill_ctrl
  import l1_ctrl_pkg::*;
#(
  parameter int LINE_BEATS = 256,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_line_req,
  input  logic                  read_req,
  input  logic                  write_through_req,
  input  logic [63:0]           pa,
  input  logic [3:0]            L1_size,
  input  logic [63:0]           wt_data,
  output logic [63:0]           line_data,
  output logic [LINE_OFS_W-1:0] addr_count,
  output logic                  line_write,
  output logic                  cache_entry_write,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [63:0]           bus_addr,
  output logic [3:0]            bus_size,
  output logic [63:0]           bus_wdata,
  input  logic [63:0]           bus_rdata,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  localparam int CNT_W = $clog2(LINE_BEATS);

  state_t r_state;
  state_t w_next;
  op_t    r_op;

  logic [63:0]           r_pa;
  logic [3:0]            r_size;
  logic [63:0]           r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic [63:0]           r_line_data;
  logic [LINE_OFS_W-1:0] r_addr_count;
  logic                  r_line_write;

  logic                  w_busy;
  logic                  w_start;
  logic                  w_expire;
  logic                  w_fail;
  logic                  w_ack;
  logic                  w_last;
  logic [LINE_OFS_W-1:0] w_ofs;

  assign w_busy  = (r_state == S_LINE) ||
                   (r_state == S_RD) ||
                   (r_state == S_WR);
  assign w_start = (r_state == S_IDLE) &&
                   (read_line_req || read_req || write_through_req);
  // Error (slave or watchdog) beats a same-cycle ack.
  assign w_fail  = w_busy && (bus_err || w_expire);
  assign w_ack   = w_busy && bus_ack && !w_fail;
  assign w_last  = (r_cnt == CNT_W'(LINE_BEATS - 1));
  assign w_ofs   = LINE_OFS_W'({r_cnt, 3'b000});

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (!w_busy || bus_ack),
    .i_run    (w_busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (read_line_req) begin
          w_next = S_LINE;
        end else if (read_req) begin
          w_next = S_RD;
        end else if (write_through_req) begin
          w_next = S_WR;
        end
      end
      S_LINE: begin
        if (w_fail) begin
          w_next = S_ERR;
        end else if (w_ack && w_last) begin
          w_next = S_DONE;
        end
      end
      S_RD, S_WR: begin
        if (w_fail) begin
          w_next = S_ERR;
        end else if (w_ack) begin
          w_next = S_DONE;
        end
      end
      S_DONE, S_ERR: w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= OP_LINE;
      r_pa         <= '0;
      r_size       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_line_data  <= '0;
      r_addr_count <= '0;
      r_line_write <= 1'b0;
    end else begin
      r_line_write <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end
      if (w_start) begin
        r_pa    <= pa;
        r_size  <= L1_size;
        r_wdata <= wt_data;
        if (read_line_req) begin
          r_op <= OP_LINE;
        end else if (read_req) begin
          r_op <= OP_RD;
        end else begin
          r_op <= OP_WR;
        end
      end
      if (w_ack && (r_state == S_LINE)) begin
        r_line_data  <= bus_rdata;
        r_addr_count <= w_ofs;
        r_line_write <= 1'b1;
        r_cnt        <= r_cnt + 1'b1;
      end
      if (w_ack && (r_state == S_RD)) begin
        r_line_data <= bus_rdata;
      end
    end
  end

  always_comb begin
    bus_req           = w_busy;
    bus_we            = (r_state == S_WR);
    bus_addr          = '0;
    bus_size          = '0;
    bus_wdata         = '0;
    trans_rdy         = (r_state == S_DONE);
    cache_entry_write = (r_state == S_DONE) && (r_op == OP_LINE);
    bus_error         = (r_state == S_ERR);
    unique case (r_state)
      S_LINE: begin
        bus_addr = {r_pa[63:LINE_OFS_W], w_ofs};
        bus_size = SZ_D;
      end
      S_RD: begin
        bus_addr = r_pa;
        bus_size = r_size;
      end
      S_WR: begin
        bus_addr  = r_pa;
        bus_size  = r_size;
        bus_wdata = r_wdata;
      end
      default: begin
        bus_addr = '0;
      end
    endcase
  end

  assign line_data  = r_line_data;
  assign addr_count = r_addr_count;
  assign line_write = r_line_write;

endmodule

// File: doc/l1_refill_ctrl.md
# l1_refill_ctrl

Bus-side sequencer for the L1 cache front-end. Accepts the L1's line-refill, single-read and write-through requests, runs them as 64-bit beats on the single-master system bus, and returns refill data, beat offsets, entry-update strobes, completion and error back to the L1. A watchdog turns a silent slave into a bus error.

## Interface
- LINE_BEATS, 256, doublewords per cache line (2 KiB line, byte offset 10:0)
- TIMEOUT, 1023, max cycles bus_req may wait for ack/err; 0 disables the watchdog
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- read_line_req  in  1  L1 wants a full line refill
- read_req  in  1  L1 wants one uncached read
- write_through_req  in  1  L1 wants one write-through
- pa  in  64  physical address from L1
- L1_size  in  4  access size: 0001 = 1 B, 0010 = 2 B, 0100 = 4 B, 1000 = 8 B
- wt_data  in  64  write-through data
- line_data  out  64  registered read data (refill beat or single read)
- addr_count  out  11  byte offset of the beat in line_data, always a multiple of 8
- line_write  out  1  one-cycle strobe: line_data/addr_count valid for the L1 array
- cache_entry_write  out  1  one-cycle strobe: refill done, L1 commits the tag
- trans_rdy  out  1  one-cycle strobe: transaction completed without error
- bus_error  out  1  one-cycle strobe: transaction aborted
- bus_req  out  1  bus cycle request, held until ack/err
- bus_we  out  1  1 = write
- bus_addr  out  64  beat address
- bus_size  out  4  beat size, same encoding as L1_size
- bus_wdata  out  64  write data
- bus_rdata  in  64  read data, valid with bus_ack
- bus_ack  in  1  beat complete
- bus_err  in  1  beat failed

## Operation
- States: IDLE, LINE, RD, WR, DONE, ERR.
- IDLE: sample requests with priority read_line_req > read_req > write_through_req; capture pa, L1_size, wt_data into registers; beat counter := 0.
- LINE: bus_req=1, bus_we=0, bus_size=1000, bus_addr={pa_q[63:11], cnt, 3'b000}. Each bus_ack: line_data<=bus_rdata, addr_count<={cnt,3'b000}, line_write pulses next cycle, cnt++. Ack on beat LINE_BEATS-1 -> DONE with cache_entry_write=1.
- RD: bus_addr=pa_q, bus_size=size_q, bus_we=0; ack -> line_data<=bus_rdata, -> DONE.
- WR: bus_addr=pa_q, bus_size=size_q, bus_we=1, bus_wdata=wt_data_q; ack -> DONE.
- DONE: trans_rdy=1 for one cycle (plus cache_entry_write when from LINE) -> IDLE.
- bus_err during bus_req, or watchdog expiry -> ERR: bus_error=1 one cycle, bus_req low, -> IDLE. No trans_rdy, no cache_entry_write; partial line writes left in the array are harmless because the tag is never committed.
- bus_err and bus_ack in the same cycle: error wins.
- bus_ack/bus_err while bus_req=0: ignored.
- Watchdog: count cycles with bus_req=1 since the last ack; reaching TIMEOUT counts as bus_err. Reset on every ack and on IDLE.
- Reset: state IDLE; all outputs 0, addr_count 0, line_data 0; an in-flight beat is abandoned at the reset edge.

## Timing
- Request seen at edge N (IDLE); bus_req high from cycle N+1.
- The final line_write, trans_rdy and cache_entry_write fall in the same cycle (the cycle after the last ack), so the L1's last array write and state exit share one edge.
- Zero-wait slave: line refill = 1 + 256 + 1 cycles request-to-trans_rdy. Single read or write = 3 cycles.
- bus_addr, bus_size, bus_we, bus_wdata stable while bus_req=1 until ack; after an ack in LINE, bus_addr advances the next cycle and bus_req stays high.
- Requests are ignored outside IDLE. The L1 drops its request the cycle after trans_rdy/bus_error, so IDLE never re-triggers.

## Structure
- Package l1_ctrl_pkg: state encoding, size encodings (SZ_B/H/W/D), LINE_OFS_W=11.
- Sub-module bus_watchdog: TIMEOUT counter with clr/run/expire.

## Test plan
- Refill pa=0x8000_1234, slave ack every cycle, rdata=beat index -> 256 line_write pulses, addr_count 0x000..0x7F8, bus_addr 0x8000_1000..0x8000_17F8; final line_write, trans_rdy and cache_entry_write in the same cycle, 258 cycles total.
- Single read pa=0x1003, size=0001, ack after 5 wait cycles, rdata=0xAB -> bus_size=0001, line_data=0xAB with trans_rdy one cycle after ack, line_write never pulses.
- Write-through pa=0x2000, wt_data=0xDEAD_BEEF, size=0100 -> bus_we=1, bus_wdata=0xDEAD_BEEF, trans_rdy once; no line_write or cache_entry_write.
- Refill with bus_err on beat 17 -> bus_error pulse, no cache_entry_write, no trans_rdy, IDLE next cycle. bus_ack together with bus_err -> still an error.
- TIMEOUT=8, silent slave on read -> bus_error 8 cycles after bus_req rises. TIMEOUT=0 -> waits indefinitely.
- rst at beat 100 of a refill -> all outputs 0 next cycle; a new read_req is then served normally.
